// File: rtl/display_pkg.sv
// display_pkg: shared digit indices, scan state and segment helpers for the display scanner.
package display_pkg;
  typedef logic [1:0] digit_t;
  typedef enum logic {BLANK, ON} scan_state_e;
  localparam digit_t DIGIT_HR_T = 2'd0;
  localparam digit_t DIGIT_HR_U = 2'd1;
  localparam digit_t DIGIT_MIN_T = 2'd2;
  localparam digit_t DIGIT_MIN_U = 2'd3;
  localparam logic [6:0] ZERO_PAT_DEF = 7'b0111111;
  function automatic logic [6:0] digit_pat(digit_t d, logic [13:0] hr, logic [13:0] mn);
    return d == DIGIT_HR_T ? hr[13:7] : d == DIGIT_HR_U ? hr[6:0] : d == DIGIT_MIN_T ? mn[13:7] : mn[6:0];
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot counter and digit index with slot_first/blank_done/slot_last strobes.
module scan_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  output digit_t digit_o,
  output logic   slot_first_o,
  output logic   blank_done_o,
  output logic   slot_last_o
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  digit_t digit_q, digit_d;
  always_comb begin
    slot_last_o = cnt_q == CW'(SCAN_DIV - 1);
    slot_first_o = cnt_q == '0;
    blank_done_o = (BLANK_CYCLES > 0) && cnt_q == CW'(BLANK_CYCLES - 1);
    cnt_d = slot_last_o ? '0 : cnt_q + 1'b1;
    digit_d = slot_last_o ? digit_q + 2'd1 : digit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      digit_q <= DIGIT_HR_T;
    end else begin
      cnt_q <= cnt_d;
      digit_q <= digit_d;
    end
  end
  assign digit_o = digit_q;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes four 7-segment digits onto one bus with frame snapshots,
// inter-digit blanking, hour-tens zero suppression and per-digit blinking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_SUPPRESS = 1,
  parameter logic [6:0] ZERO_PAT = ZERO_PAT_DEF
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic [13:0] hr_wire,
  input  logic [13:0] min_wire,
  input  logic        am_pm_wire,
  input  logic        blink_en,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an_out,
  output logic        frame_start
);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  digit_t digit;
  logic slot_first, blank_done, slot_last;
  logic frame_first, frame_last, lz, hide, vis;
  scan_state_e state_q, st;
  logic [28:0] snap_q, snap_d;
  logic [FW-1:0] fcnt_q;
  logic hidden_q, fwrap;
  logic [6:0] seg_q;
  logic [3:0] an_q;
  logic dp_q, fs_q;
  scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(CLOCK), .rst(reset), .digit_o(digit),
    .slot_first_o(slot_first), .blank_done_o(blank_done), .slot_last_o(slot_last)
  );
  always_comb begin
    frame_first = slot_first && digit == DIGIT_HR_T;
    frame_last = slot_last && digit == DIGIT_MIN_U;
    snap_d = frame_first ? {hr_wire, min_wire, am_pm_wire} : snap_q;
    st = BLANK_CYCLES == 0 ? ON : state_q;
    lz = (LZ_SUPPRESS != 0) && digit == DIGIT_HR_T && snap_d[28:22] == ZERO_PAT;
    hide = blink_en && hidden_q && blink_mask[digit];
    vis = st == ON && !lz && !hide;
    fwrap = fcnt_q == FW'(BLINK_FRAMES - 1);
  end
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= BLANK;
      snap_q <= '0;
      fcnt_q <= '0;
      hidden_q <= 1'b0;
      seg_q <= '0;
      an_q <= '0;
      dp_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      fs_q <= frame_first;
      seg_q <= vis ? digit_pat(digit, snap_d[28:15], snap_d[14:1]) : '0;
      an_q <= vis ? 4'b0001 << digit : '0;
      dp_q <= vis && digit == DIGIT_MIN_U && snap_d[0];
      state_q <= slot_last ? (BLANK_CYCLES == 0 ? ON : BLANK) : blank_done ? ON : state_q;
      // Advance on the edge that opens the next frame so a whole frame shares one phase.
      if (frame_last) begin
        fcnt_q <= fwrap ? '0 : fcnt_q + 1'b1;
        hidden_q <= fwrap ? !hidden_q : hidden_q;
      end
    end
  end
  assign seg_out = seg_q;
  assign an_out = an_q;
  assign dp_out = dp_q;
  assign frame_start = fs_q;
endmodule
